// File: rtl/branch_pkg.sv
// Shared constants for the branch resolver: result bit positions, PC step, and the
// packed layout of a queued prediction {taken, pc, target}.
package branch_pkg;

  localparam int RES_W     = 3;
  localparam int RES_VALID = 2;
  localparam int RES_PRED  = 1;
  localparam int RES_ACT   = 0;

  localparam int PC_STEP = 4;

  localparam int ENT_TAKEN_W = 1;

  function automatic int ent_width(input int xlen);
    return ENT_TAKEN_W + 2 * xlen;
  endfunction

  function automatic int ent_tgt_off(input int xlen);
    return 0 * xlen;
  endfunction

  function automatic int ent_pc_off(input int xlen);
    return xlen;
  endfunction

  function automatic int ent_taken_off(input int xlen);
    return 2 * xlen;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch/execute-facing signal bundle of the branch resolver; master drives predictions and
// resolutions, slave (the resolver) returns result, flush/redirect, status and statistics.
interface branch_resolver_if #(parameter int XLEN = 32);
  import branch_pkg::*;

  logic             pred_valid;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_pc;
  logic [XLEN-1:0]  pred_target;
  logic             resolve_valid;
  logic             resolve_taken;
  logic [XLEN-1:0]  resolve_target;
  logic [RES_W-1:0] result;
  logic             mispredict;
  logic [XLEN-1:0]  redirect_pc;
  logic             full;
  logic             underflow_err;
  logic [31:0]      stat_total;
  logic [31:0]      stat_miss;

  modport master (
    output pred_valid, pred_taken, pred_pc, pred_target,
    output resolve_valid, resolve_taken, resolve_target,
    input  result, mispredict, redirect_pc, full, underflow_err, stat_total, stat_miss
  );

  modport slave (
    input  pred_valid, pred_taken, pred_pc, pred_target,
    input  resolve_valid, resolve_taken, resolve_target,
    output result, mispredict, redirect_pc, full, underflow_err, stat_total, stat_miss
  );

endinterface

// File: rtl/branch_pred_fifo.sv
// In-order prediction queue: head is combinational from state, writes land on the next edge.
// Caller gates push against full (a push while full is only legal alongside a pop); clear wins.
module branch_pred_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             clear,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/branch_resolver.sv
// Compares queued fetch predictions with execute outcomes; result/flush/redirect registered, 1-cycle latency.
// Fetch stalls on full; a miss flushes the queue. Optional counters: BRANCH_RESOLVER_STATS_EN.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic              clk,
  input logic              rst,
  branch_resolver_if.slave bus
);

  localparam int EW        = ent_width(XLEN);
  localparam int TGT_OFF   = ent_tgt_off(XLEN);
  localparam int PC_OFF    = ent_pc_off(XLEN);
  localparam int TAKEN_OFF = ent_taken_off(XLEN);

  logic            q_full;
  logic            q_empty;
  logic [EW-1:0]   q_head;
  logic [EW-1:0]   q_push_dat;
  logic            head_taken;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_tgt;

  logic            pop;
  logic            push;
  logic            dir_ok;
  logic            tgt_ok;
  logic            miss;
  logic            kill;
  logic [XLEN-1:0] redirect_nxt;

  logic [RES_W-1:0] result_q;
  logic             mispredict_q;
  logic [XLEN-1:0]  redirect_q;
  logic             underflow_q;

  assign q_push_dat = {bus.pred_taken, bus.pred_pc, bus.pred_target};
  assign head_taken = q_head[TAKEN_OFF];
  assign head_pc    = q_head[PC_OFF +: XLEN];
  assign head_tgt   = q_head[TGT_OFF +: XLEN];

  assign pop    = bus.resolve_valid && !q_empty;
  assign dir_ok = (head_taken == bus.resolve_taken);
  assign tgt_ok = !bus.resolve_taken || (head_tgt == bus.resolve_target);
  assign miss   = pop && !(dir_ok && tgt_ok);

  // Wrong-path fetches: drop pushes on the miss edge and while the flush pulse is out.
  assign kill = miss || mispredict_q;
  assign push = bus.pred_valid && !kill && (!q_full || pop);

  assign redirect_nxt = bus.resolve_taken ? bus.resolve_target : head_pc + XLEN'(PC_STEP);

  branch_pred_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (q_push_dat),
    .pop      (pop),
    .clear    (miss),
    .full     (q_full),
    .empty    (q_empty),
    .head     (q_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q     <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      underflow_q  <= 1'b0;
    end else begin
      result_q     <= pop ? {1'b1, head_taken, bus.resolve_taken} : '0;
      mispredict_q <= miss;
      if (miss) redirect_q <= redirect_nxt;
      if (bus.resolve_valid && q_empty) underflow_q <= 1'b1;
    end
  end

  assign bus.result        = result_q;
  assign bus.mispredict    = mispredict_q;
  assign bus.redirect_pc   = redirect_q;
  assign bus.full          = q_full;
  assign bus.underflow_err = underflow_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] total_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q    <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (pop && total_q != 32'hFFFF_FFFF)    total_q    <= total_q + 32'd1;
      if (miss && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign bus.stat_total = total_q;
  assign bus.stat_miss  = miss_cnt_q;
`else
  assign bus.stat_total = '0;
  assign bus.stat_miss  = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: stimulus queues expected responses, a negedge monitor
// pops and compares them whenever the resolver reports a result.
module tb_branch_resolver;

  logic clk;
  logic rst;

  branch_resolver_if #(.XLEN(32)) bif ();

  branch_resolver #(.DEPTH(4), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  typedef struct {
    logic [2:0]  res;
    logic        miss;
    logic [31:0] rpc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   m_total = 0;
  int   m_miss  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bif.result[2]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_result: got %b with no pop outstanding", bif.result);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", 32'(bif.result), 32'(mon_e.res));
        chk("mispredict", 32'(bif.mispredict), 32'(mon_e.miss));
        if (mon_e.miss) chk("redirect_pc", bif.redirect_pc, mon_e.rpc);
      end
    end else if (!rst && bif.mispredict) begin
      checks++;
      errors++;
      $display("FAIL stray_mispredict: got 1 without result valid, expected 0");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic tk, input logic [31:0] pc, input logic [31:0] tgt);
    bif.pred_valid  = 1'b1;
    bif.pred_taken  = tk;
    bif.pred_pc     = pc;
    bif.pred_target = tgt;
    step();
    bif.pred_valid  = 1'b0;
  endtask

  // Leaves pred_* untouched so a caller can overlap a push with the pop.
  task automatic resolve(input logic tk, input logic [31:0] tgt,
                         input logic [2:0] eres, input logic emiss, input logic [31:0] erpc);
    exp_t e;
    e.res  = eres;
    e.miss = emiss;
    e.rpc  = erpc;
    exp_q.push_back(e);
    m_total++;
    if (emiss) m_miss++;
    bif.resolve_valid  = 1'b1;
    bif.resolve_taken  = tk;
    bif.resolve_target = tgt;
    step();
    bif.resolve_valid  = 1'b0;
  endtask

  task automatic chk_stats();
`ifdef BRANCH_RESOLVER_STATS_EN
    chk("stat_total", bif.stat_total, 32'(m_total));
    chk("stat_miss", bif.stat_miss, 32'(m_miss));
`else
    chk("stat_total", bif.stat_total, 32'h0);
    chk("stat_miss", bif.stat_miss, 32'h0);
`endif
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bif.pred_valid     = 1'b0;
    bif.pred_taken     = 1'b0;
    bif.pred_pc        = '0;
    bif.pred_target    = '0;
    bif.resolve_valid  = 1'b0;
    bif.resolve_taken  = 1'b0;
    bif.resolve_target = '0;
    #1;
    chk("rst_result", 32'(bif.result), 32'h0);
    chk("rst_mispredict", 32'(bif.mispredict), 32'h0);
    chk("rst_redirect", bif.redirect_pc, 32'h0);
    chk("rst_full", 32'(bif.full), 32'h0);
    chk("rst_underflow", 32'(bif.underflow_err), 32'h0);
    chk_stats();
    repeat (2) step();
    rst = 1'b0;
    step();

    // Correct taken prediction, then the result pulse must drop.
    push(1'b1, 32'h100, 32'h200);
    resolve(1'b1, 32'h200, 3'b111, 1'b0, 32'h0);
    step();
    chk("t1_result_pulse", 32'(bif.result), 32'h0);

    // Predicted not-taken, actually taken.
    push(1'b0, 32'h100, 32'h0);
    resolve(1'b1, 32'h180, 3'b101, 1'b1, 32'h180);
    chk("t2_mispredict", 32'(bif.mispredict), 32'h1);
    chk("t2_redirect", bif.redirect_pc, 32'h180);
    step();
    chk("t2_mispredict_pulse", 32'(bif.mispredict), 32'h0);

    // Fall-through PC wraps past the top of the address space.
    push(1'b1, 32'hFFFF_FFFC, 32'h40);
    resolve(1'b0, 32'h0, 3'b110, 1'b1, 32'h0);
    step();

    // Fill, drop an overflow push, then pop+push while full.
    push(1'b1, 32'h10, 32'hA0);
    push(1'b0, 32'h14, 32'h0);
    push(1'b1, 32'h18, 32'hC0);
    push(1'b0, 32'h1C, 32'h0);
    chk("t4_full", 32'(bif.full), 32'h1);
    push(1'b1, 32'h20, 32'hE0);
    chk("t4_full_after_drop", 32'(bif.full), 32'h1);
    bif.pred_valid  = 1'b1;
    bif.pred_taken  = 1'b0;
    bif.pred_pc     = 32'h24;
    bif.pred_target = 32'h0;
    resolve(1'b1, 32'hA0, 3'b111, 1'b0, 32'h0);
    bif.pred_valid  = 1'b0;
    chk("t4_full_pop_push", 32'(bif.full), 32'h1);
    resolve(1'b0, 32'h0, 3'b100, 1'b0, 32'h0);
    resolve(1'b1, 32'hC0, 3'b111, 1'b0, 32'h0);
    resolve(1'b0, 32'h0, 3'b100, 1'b0, 32'h0);
    resolve(1'b0, 32'h0, 3'b100, 1'b0, 32'h0);
    chk("t4_drained", 32'(bif.full), 32'h0);

    // Head miss with a concurrent push, then a push during the flush pulse.
    push(1'b1, 32'h300, 32'h400);
    push(1'b1, 32'h304, 32'h404);
    push(1'b1, 32'h308, 32'h408);
    bif.pred_valid  = 1'b1;
    bif.pred_taken  = 1'b1;
    bif.pred_pc     = 32'h999;
    bif.pred_target = 32'h777;
    resolve(1'b0, 32'h0, 3'b110, 1'b1, 32'h304);
    chk("t5_kill_pulse", 32'(bif.mispredict), 32'h1);
    bif.pred_pc     = 32'h888;
    bif.pred_target = 32'h666;
    step();
    bif.pred_valid  = 1'b0;
    push(1'b0, 32'h500, 32'h0);
    resolve(1'b0, 32'h0, 3'b100, 1'b0, 32'h0);
    step();
    chk_stats();

    // Underflow is sticky and leaves result/mispredict alone.
    bif.resolve_valid = 1'b1;
    bif.resolve_taken = 1'b1;
    step();
    bif.resolve_valid = 1'b0;
    chk("t6_uf_result", 32'(bif.result), 32'h0);
    chk("t6_uf_mispredict", 32'(bif.mispredict), 32'h0);
    chk("t6_underflow", 32'(bif.underflow_err), 32'h1);
    repeat (3) step();
    chk("t6_underflow_sticky", 32'(bif.underflow_err), 32'h1);

    // Asynchronous reset mid-cycle with a full queue.
    push(1'b1, 32'h40, 32'h50);
    push(1'b1, 32'h44, 32'h54);
    push(1'b1, 32'h48, 32'h58);
    push(1'b1, 32'h4C, 32'h5C);
    chk("t6_full_before_rst", 32'(bif.full), 32'h1);
    #2;
    rst = 1'b1;
    m_total = 0;
    m_miss  = 0;
    #1;
    chk("t6_rst_full", 32'(bif.full), 32'h0);
    chk("t6_rst_underflow", 32'(bif.underflow_err), 32'h0);
    chk("t6_rst_redirect", bif.redirect_pc, 32'h0);
    chk_stats();
    step();
    rst = 1'b0;
    step();

    // Three pops, one miss.
    push(1'b1, 32'h800, 32'h900);
    push(1'b0, 32'h804, 32'h0);
    push(1'b1, 32'h808, 32'h908);
    resolve(1'b1, 32'h900, 3'b111, 1'b0, 32'h0);
    resolve(1'b0, 32'h0, 3'b100, 1'b0, 32'h0);
    resolve(1'b1, 32'h90C, 3'b111, 1'b1, 32'h90C);
    chk_stats();

    repeat (3) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
